// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t    : FSM encoding used by seq_div_16by8 (IDLE, CALC, DONE)
//   DW_DEFAULT : default divisor/remainder width
//   cnt_width  : width of the iteration counter for a given DW
package seq_div_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One counter value per quotient bit: 2*DW steps.
  function automatic int cnt_width(input int dw);
    return $clog2(2 * dw);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring compare-subtract step (purely combinational).
//   r      in  DW+1  current partial remainder
//   q_msb  in  1     next dividend bit shifted in from the quotient register
//   d      in  DW    divisor
//   r_next out DW+1  partial remainder after this step
//   q_bit  out 1     quotient bit produced by this step
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   r,
  input  logic          q_msb,
  input  logic [DW-1:0] d,
  output logic [DW:0]   r_next,
  output logic          q_bit
);

  logic [DW:0] t;
  logic [DW:0] d_ext;
  logic [DW:0] diff;

  // Working in DW+1 bits means the shifted remainder never overflows.
  assign t     = {r[DW-1:0], q_msb};
  assign d_ext = {1'b0, d};
  assign diff  = t - d_ext;

  // Every step leaves R < D, so r[DW] is normally 0. If it were ever set,
  // the true shifted value would exceed any divisor, so it forces a subtract.
  assign q_bit  = r[DW] | (t >= d_ext);
  assign r_next = q_bit ? diff : t;

endmodule

// File: rtl/seq_div_16by8.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : operands valid        in_ready  : accepting (IDLE only)
//   dividend   : 2*DW-bit numerator     divisor   : DW-bit denominator
//   out_valid  : result valid (DONE)    out_ready : consumer takes result
//   quotient   : 2*DW-bit quotient      remainder : DW-bit remainder
//   div_zero   : current result came from a divide-by-zero request
// One operation in flight; a divide-by-zero skips straight to DONE with
// quotient all-ones and remainder equal to the low DW dividend bits.
module seq_div_16by8
  import seq_div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero
);

  localparam int CW = cnt_width(DW);

  state_t          state_reg, state_next;
  logic [2*DW-1:0] q_reg, q_next;
  logic [DW-1:0]   d_reg, d_next;
  logic [DW:0]     r_reg, r_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            dz_reg, dz_next;

  logic [DW:0]     step_r;
  logic            step_q;

  div_step #(.DW(DW)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[2*DW-1]),
    .d      (d_reg),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    r_next     = r_reg;
    cnt_next   = cnt_reg;
    dz_next    = dz_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          q_next   = dividend;
          d_next   = divisor;
          r_next   = '0;
          cnt_next = '0;
          if (divisor == '0) begin
            state_next = DONE;
            dz_next    = 1'b1;
            q_next     = '1;
            r_next     = {1'b0, dividend[DW-1:0]};
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        // Dividend bits leave the top of Q while quotient bits enter the bottom.
        r_next   = step_r;
        q_next   = {q_reg[2*DW-2:0], step_q};
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(2 * DW - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // No refill on the consume edge: IDLE must be visited first.
        if (out_ready) begin
          state_next = IDLE;
          dz_next    = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      r_reg     <= r_next;
      cnt_reg   <= cnt_next;
      dz_reg    <= dz_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign quotient  = q_reg;
  assign remainder = r_reg[DW-1:0];
  assign div_zero  = dz_reg;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Self-checking bench for seq_div_16by8 (DW=8). Expected results come from
// plain integer division in ref_div; the random sweep also checks the
// identity q*d + r == dividend with r < d.
module tb_seq_div_16by8;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] quotient;
  logic [DW-1:0]   remainder;
  logic            div_zero;

  int tests_run = 0;
  int fails     = 0;

  seq_div_16by8 #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Reference: exact unsigned division; divide-by-zero returns all-ones and
  // the low byte of the dividend.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output bit dz);
    if (b == 0) begin
      q = 16'hFFFF; r = a & 8'hFF; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Present operands for one edge; afterwards scramble them to show the
  // design does not depend on operands after the accept edge.
  task automatic send(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, div_zero} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags: got rdy/vld/dz=%b required 100", {in_ready, out_valid, div_zero});
    end
    tests_run++;
    if (quotient !== 16'd0 || remainder !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: got q=%0d r=%0d required q=0 r=0", quotient, remainder);
    end
  endtask

  task automatic test_directed();
    logic [2*DW-1:0] va [5] = '{16'd1000, 16'd65025, 16'd65535, 16'd0, 16'd255};
    logic [DW-1:0]   vb [5] = '{8'd7,    8'd255,    8'd1,      8'd5,  8'd255};
    int eq, er, lat;
    bit edz;
    for (int i = 0; i < 5; i++) begin
      ref_div(int'(va[i]), int'(vb[i]), eq, er, edz);
      tests_run++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL directed_ready[%0d]: got in_ready=%b required 1", i, in_ready);
      end
      send(va[i], vb[i]);
      wait_done(lat);
      $display("[TB] %0d / %0d -> q=%0d r=%0d dz=%b lat=%0d", va[i], vb[i], quotient, remainder, div_zero, lat);
      tests_run++;
      if (lat !== 2 * DW) begin
        fails++;
        $display("FAIL directed_latency[%0d]: got %0d edges required %0d", i, lat, 2 * DW);
      end
      tests_run++;
      if (quotient !== 16'(eq) || remainder !== 8'(er) || div_zero !== edz) begin
        fails++;
        $display("FAIL directed_result[%0d]: got q=%0d r=%0d dz=%b required q=%0d r=%0d dz=%b",
                 i, quotient, remainder, div_zero, eq, er, edz);
      end
      consume();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL directed_consume[%0d]: got vld=%b rdy=%b required vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
    // Anchor the model against the hand-worked value.
    send(16'd1000, 8'd7);
    wait_done(lat);
    tests_run++;
    if (quotient !== 16'd142 || remainder !== 8'd6) begin
      fails++;
      $display("FAIL directed_1000_7: got q=%0d r=%0d required q=142 r=6", quotient, remainder);
    end
    consume();
  endtask

  task automatic test_div_zero();
    int lat;
    send(16'd5, 8'd0);
    wait_done(lat);
    $display("[TB] 5 / 0 -> q=%0h r=%0d dz=%b lat=%0d", quotient, remainder, div_zero, lat);
    // out_valid must already be high right after the accept edge.
    tests_run++;
    if (lat !== 0) begin
      fails++;
      $display("FAIL divzero_latency: got %0d extra edges required 0", lat);
    end
    tests_run++;
    if (quotient !== 16'hFFFF || remainder !== 8'd5 || div_zero !== 1'b1) begin
      fails++;
      $display("FAIL divzero_result: got q=%0h r=%0d dz=%b required q=ffff r=5 dz=1", quotient, remainder, div_zero);
    end
    consume();
    tests_run++;
    if (div_zero !== 1'b0) begin
      fails++;
      $display("FAIL divzero_clear: got dz=%b required 0", div_zero);
    end
    send(16'd10, 8'd3);
    wait_done(lat);
    $display("[TB] 10 / 3 -> q=%0d r=%0d dz=%b lat=%0d", quotient, remainder, div_zero, lat);
    tests_run++;
    if (quotient !== 16'd3 || remainder !== 8'd1 || div_zero !== 1'b0 || lat !== 2 * DW) begin
      fails++;
      $display("FAIL divzero_next: got q=%0d r=%0d dz=%b lat=%0d required q=3 r=1 dz=0 lat=16",
               quotient, remainder, div_zero, lat);
    end
    consume();
  endtask

  task automatic test_back_pressure();
    int lat;
    send(16'd300, 8'd17);
    wait_done(lat);
    $display("[TB] 300 / 17 -> q=%0d r=%0d lat=%0d (held)", quotient, remainder, lat);
    tests_run++;
    if (quotient !== 16'd17 || remainder !== 8'd11 || lat !== 2 * DW) begin
      fails++;
      $display("FAIL bp_result: got q=%0d r=%0d lat=%0d required q=17 r=11 lat=16", quotient, remainder, lat);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      dividend = 16'd1234;
      divisor  = 8'd5;
      @(posedge clk); #1;
      tests_run++;
      if (quotient !== 16'd17 || remainder !== 8'd11 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got q=%0d r=%0d vld=%b rdy=%b required q=17 r=11 vld=1 rdy=0",
                 c, quotient, remainder, out_valid, in_ready);
      end
    end
    // in_valid coincident with the consume edge must not start a new divide.
    in_valid = 1'b1; dividend = 16'd99; divisor = 8'd9;
    consume();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_consume: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_no_refill: got rdy=%b required 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    send(16'd1000, 8'd7);
    repeat (8) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, div_zero} !== 3'b100 || quotient !== 16'd0 || remainder !== 8'd0) begin
      fails++;
      $display("FAIL midreset_state: got rdy/vld/dz=%b q=%0d r=%0d required 100 q=0 r=0",
               {in_ready, out_valid, div_zero}, quotient, remainder);
    end
    send(16'd50, 8'd8);
    wait_done(lat);
    $display("[TB] 50 / 8 -> q=%0d r=%0d lat=%0d (after reset)", quotient, remainder, lat);
    tests_run++;
    if (quotient !== 16'd6 || remainder !== 8'd2 || lat !== 2 * DW) begin
      fails++;
      $display("FAIL midreset_fresh: got q=%0d r=%0d lat=%0d required q=6 r=2 lat=16", quotient, remainder, lat);
    end
    consume();
  endtask

  task automatic test_random_sweep();
    int a, b, eq, er, lat, hold, qi, ri;
    bit edz;
    for (int i = 0; i < 1000; i++) begin
      a    = int'($urandom_range(0, 65535));
      b    = i % 256;           // every divisor, including 0, gets exercised
      hold = int'($urandom_range(0, 2));
      ref_div(a, b, eq, er, edz);
      send(16'(a), 8'(b));
      wait_done(lat);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      qi = int'(quotient);
      ri = int'(remainder);
      $display("[TB] rnd %0d / %0d -> q=%0d r=%0d dz=%b lat=%0d", a, b, qi, ri, div_zero, lat);
      tests_run++;
      if (qi != eq || ri != er || div_zero !== edz || lat != (edz ? 0 : 2 * DW)) begin
        fails++;
        $display("FAIL rnd_result[%0d]: %0d/%0d got q=%0d r=%0d dz=%b lat=%0d required q=%0d r=%0d dz=%b",
                 i, a, b, qi, ri, div_zero, lat, eq, er, edz);
      end
      if (b != 0) begin
        tests_run++;
        if (qi * b + ri != a || ri >= b) begin
          fails++;
          $display("FAIL rnd_identity[%0d]: %0d/%0d got q=%0d r=%0d (q*d+r must equal dividend, r<d)",
                   i, a, b, qi, ri);
        end
      end
      consume();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    test_reset();
    test_directed();
    test_div_zero();
    test_back_pressure();
    test_reset_mid_op();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/seq_div_16by8.md
# seq_div_16by8

Sequential radix-2 restoring divider. It takes a 2·DW-bit dividend and a DW-bit divisor and returns a 2·DW-bit quotient and a DW-bit remainder. It is the inverse datapath of the team's 8x8 approximate multipliers. Its main use is as the checking path in multiplier error-characterisation benches: products from the multiplier are divided back by one operand, and the recovered operand is compared against the original. Input and output use valid/ready handshakes. The block holds one operation in flight.

## Interface
Parameters:
- DW, 8, divisor/remainder width; dividend and quotient are 2·DW bits.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- dividend  in  2·DW  numerator, unsigned.
- divisor  in  DW  denominator, unsigned.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- quotient  out  2·DW  unsigned quotient.
- remainder  out  DW  unsigned remainder, always < divisor when divisor ≠ 0.
- div_zero  out  1  result belongs to a divide-by-zero request.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture dividend into quotient shift register Q and divisor into D.
  - Clear partial remainder R (DW+1 bits) and iteration counter cnt (log2(2·DW) bits).
  - If divisor==0: go to DONE with div_zero=1, quotient=all-ones, remainder=dividend[DW-1:0].
  - Otherwise go to CALC.
- CALC, one step per cycle:
  - T = {R[DW-1:0], Q[msb]}.
  - If T ≥ {1'b0,D}: R=T−D, new quotient bit=1. Else: R=T, new bit=0.
  - Q shifts left, new bit enters the LSB.
  - cnt increments; after the step with cnt==2·DW−1, go to DONE.
- DONE:
  - out_valid=1; quotient=Q, remainder=R[DW-1:0].
  - Outputs are held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE and clear div_zero.
- in_valid in any state other than IDLE is ignored: no capture, in_ready=0.
- Operands need not stay stable after the accept edge.
- Arithmetic is exact and unsigned. The comparison uses DW+1 bits so that T never overflows.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, div_zero=0.
  - quotient=0, remainder=0, cnt=0.
- Reset asserted in any state wins over every handshake in the same cycle. Any in-flight operation is discarded, with no partial output.
- Normal latency: accept edge E0. CALC steps occur on E1..E2·DW. out_valid is high in the cycle after E2·DW, i.e. after 16 edges for DW=8.
- Divide-by-zero latency: out_valid is high in the cycle after E0, i.e. after 1 edge.
- Result-consume edge: out_valid falls and in_ready rises in the next cycle. There is no same-cycle refill, so back-to-back throughput is one operation per 2·DW+2 cycles.
- in_valid asserted simultaneously with the result-consume edge is not accepted. in_ready is 0 in that cycle.

## Structure
- Package seq_div_pkg holds:
  - the state enum {IDLE, CALC, DONE};
  - localparam DW_DEFAULT=8;
  - the helper function for counter width, clog2(2·DW).
- One combinational sub-module, div_step, holds the compare-subtract. It takes R, the Q MSB and D, and returns next R and the quotient bit. This keeps the step reusable for a future unrolled or approximate variant.
- The top level contains only the FSM, counter, registers and handshake logic.

## Test plan
- 1000 / 7 → quotient=142, remainder=6, div_zero=0. out_valid rises exactly 16 cycles after the accept edge.
- 65025 (255·255) / 255 → quotient=255, remainder=0. 65535 / 1 → quotient=65535, remainder=0.
- 5 / 0 → quotient=16'hFFFF, remainder=5, div_zero=1. out_valid is high 1 cycle after accept. The next request 10/3 → 3 r 1 with div_zero=0.
- Back-pressure: 300/17 with out_ready=0 for 5 cycles after out_valid. quotient=17 and remainder=11 stay stable. in_ready stays 0 and an in_valid pulse in that window is not captured.
- Reset mid-operation: assert rst at cycle 8 of CALC for 1000/7. The next cycle shows IDLE, in_ready=1, out_valid=0 and outputs 0. A fresh 50/8 → 6 r 2.
- Random sweep of all DW=8 divisors against 1000 random dividends, checked against a reference model of q·d+r==dividend with r<d.
